uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Stand-alone buffered UART transmitter (8N1, optional second stop bit) for firmware/status
//  traffic toward the host. Bytes are pushed over a valid/ready handshake into an internal
//  FIFO and serialised on TxD back-to-back. TxD is true polarity (idle high); any line
//  inversion for the level converter is done at top level, outside this block.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD_RATE   9600        line rate, bit/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (truncated, >=2)
//  FIFO_DEPTH  16          byte entries; power of 2, >=2
//  STOP_BITS   1           1 or 2 stop bits per frame
// PORTS
//  clk         in   1      single system clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  tx_data     in   8      byte to send
//  tx_valid    in   1      tx_data valid; push occurs when tx_valid && tx_ready
//  tx_ready    out  1      FIFO not full (registered)
//  fifo_count  out  log2(FIFO_DEPTH)+1  bytes currently queued (excludes byte on the wire)
//  busy        out  1      high whenever state != IDLE
//  TxD         out  1      serial line, idle high
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, FIFO empty, pointers/counters 0, TxD=1, busy=0,
//    tx_ready=1, fifo_count=0. Reset mid-frame aborts it at once: TxD=1 next cycle, queue lost.
//  - FIFO: write ptr/read ptr wrap modulo FIFO_DEPTH; count tracks occupancy.
//    Push ignored when full (tx_ready=0). Simultaneous push+pop: count unchanged, both accepted
//    (push when full is not possible; pop frees a slot visible on tx_ready next cycle).
//  - FSM states IDLE, START, DATA, STOP. Baud counter counts 0..BAUD_DIV-1; every bit period
//    is exactly BAUD_DIV clocks.
//    IDLE : TxD=1. If FIFO non-empty at edge: pop head into shift reg, go START, baud cnt=0.
//    START: TxD=0 for BAUD_DIV clocks, then DATA with bit index 0.
//    DATA : TxD=shift[0] (LSB first); at end of each period shift right; after bit 7 -> STOP.
//    STOP : TxD=1 for STOP_BITS*BAUD_DIV clocks. At end: if FIFO non-empty, pop and go START
//           directly (no idle gap); else IDLE.
//  - Latency: byte accepted at edge N into empty FIFO while IDLE -> START entered at edge N+1,
//    TxD falls in cycle after edge N+1. Frame length = (9+STOP_BITS)*BAUD_DIV clocks.
//  - tx_data is sampled only at the accepting edge; changes afterwards have no effect.
//  - TxD is a flop output (no glitches); busy is registered with state.
// TESTING  (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BAUD_DIV=10)
//  1 Reset: rst high 3 cycles -> TxD=1, busy=0, tx_ready=1, fifo_count=0.
//  2 Single byte 0xA5 pushed at edge N -> TxD low from N+1 for 10 clk, then bits
//    1,0,1,0,0,1,0,1 each 10 clk, stop high 10 clk; busy low after edge N+101.
//  3 Burst: push 0x00,0xFF,0x55 on consecutive cycles -> three frames back-to-back,
//    no idle gap between stop and next start; fifo_count 2 after first pop, 0 at the end.
//  4 Full: push 17 bytes with TX stalled in frame -> tx_ready=0 at count 16, extra push
//    dropped; first pop restores tx_ready=1; serialised order matches push order.
//  5 STOP_BITS=2, byte 0x80 -> stop high for 20 clk; total frame 110 clk.
//  6 Reset mid-DATA of 0x3C -> TxD=1 cycle after reset edge, FIFO empty, no further start bit.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter (optional second stop bit).
// A valid/ready push port feeds a FIFO that drains back-to-back onto TxD. TxD idles high.
`default_nettype none

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        TxD
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(STOP_BITS * BAUD_DIV);

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             txd_d;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_d;
  logic             push, pop, fifo_nonempty;

  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (fifo_count != '0);

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + CNT_W'(1);
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    txd_d      = TxD;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          txd_d      = shift[0];
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            txd_d     = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_cnt == STOP_LAST) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d = fifo_count;
    case ({push, pop})
      2'b10:   count_d = fifo_count + (PTR_W + 1)'(1);
      2'b01:   count_d = fifo_count - (PTR_W + 1)'(1);
      default: count_d = fifo_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      TxD        <= 1'b1;
      busy       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      TxD        <= txd_d;
      busy       <= (state_d != IDLE);
      fifo_count <= count_d;
      tx_ready   <= (count_d != FULL_COUNT);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo at BAUD_DIV=10, one and two stop bits.
`default_nettype none

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data1 = 8'd0, data2 = 8'd0;
  logic       valid1 = 1'b0, valid2 = 1'b0;
  logic       ready1, ready2, busy1, busy2, txd1, txd2;
  logic [4:0] count1, count2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
    .fifo_count(count1), .busy(busy1), .TxD(txd1));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(data2), .tx_valid(valid2), .tx_ready(ready2),
    .fifo_count(count2), .busy(busy2), .TxD(txd2));

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;   // line[k] = TxD level during bit period k, start bit at k=0
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input bit sel, input logic [7:0] b);
    if (sel) begin data2 = b; valid2 = 1'b1; end
    else     begin data1 = b; valid1 = 1'b1; end
    tick();
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  // Called at the first sample point of bit period k0/10; returns one sample past the frame.
  task automatic expect_frame(input logic [10:0] line, input int nbits, input bit sel, input int k0);
    for (int k = k0; k < nbits * 10; k++) begin
      chk("frame_txd", 32'(sel ? txd2 : txd1), 32'(line[k / 10]));
      chk("frame_busy", 32'(sel ? busy2 : busy1), 32'd1);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 11'b11_1010_0101_0};
    vecs[1] = '{8'h3C, 11'b11_0011_1100_0};
    vecs[2] = '{8'h01, 11'b11_0000_0001_0};
    vecs[3] = '{8'h80, 11'b11_1000_0000_0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_txd", 32'(txd1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_count", 32'(count1), 32'd0);
    chk("rst_txd2", 32'(txd2), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    tick();

    // Single frames from idle, including 0xA5
    for (int v = 0; v < 4; v++) begin
      push(1'b0, vecs[v].data);
      chk("vec_count_after_push", 32'(count1), 32'd1);
      chk("vec_txd_idle", 32'(txd1), 32'd1);
      chk("vec_busy_idle", 32'(busy1), 32'd0);
      tick();
      expect_frame(vecs[v].line, 10, 1'b0, 0);
      chk("vec_busy_end", 32'(busy1), 32'd0);
      chk("vec_txd_end", 32'(txd1), 32'd1);
      chk("vec_count_end", 32'(count1), 32'd0);
      repeat (3) tick();
    end

    // Burst of three bytes on consecutive cycles
    data1 = 8'h00; valid1 = 1'b1;
    tick();
    data1 = 8'hFF;
    tick();
    chk("burst_start_txd", 32'(txd1), 32'd0);
    chk("burst_count1", 32'(count1), 32'd1);
    data1 = 8'h55;
    tick();
    valid1 = 1'b0;
    chk("burst_count2", 32'(count1), 32'd2);
    expect_frame(11'b11_0000_0000_0, 10, 1'b0, 1);
    chk("burst_count_ff", 32'(count1), 32'd1);
    expect_frame(11'b11_1111_1111_0, 10, 1'b0, 0);
    chk("burst_count_55", 32'(count1), 32'd0);
    expect_frame(11'b11_0101_0101_0, 10, 1'b0, 0);
    chk("burst_busy_end", 32'(busy1), 32'd0);
    chk("burst_count_end", 32'(count1), 32'd0);
    repeat (3) tick();

    // Fill the FIFO while a frame is on the wire; the 17th push must be dropped
    push(1'b0, 8'h10);
    tick();
    for (int i = 0; i < 17; i++) begin
      data1 = 8'h20 + 8'(i);
      valid1 = 1'b1;
      tick();
      chk("full_count", 32'(count1), (i < 16) ? 32'(i + 1) : 32'd16);
      chk("full_ready", 32'(ready1), (i >= 15) ? 32'd0 : 32'd1);
    end
    valid1 = 1'b0;
    begin
      int n = 0;
      while (count1 != 5'd15 && n < 150) begin
        tick();
        n++;
      end
    end
    chk("full_pop_count", 32'(count1), 32'd15);
    chk("full_pop_ready", 32'(ready1), 32'd1);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'h20 + 8'(i);
      expect_frame({2'b11, b, 1'b0}, 10, 1'b0, 0);
    end
    chk("full_busy_end", 32'(busy1), 32'd0);
    chk("full_count_end", 32'(count1), 32'd0);
    chk("full_txd_end", 32'(txd1), 32'd1);

    // Two stop bits
    push(1'b1, 8'h80);
    chk("stop2_count", 32'(count2), 32'd1);
    tick();
    expect_frame(11'b11_1000_0000_0, 11, 1'b1, 0);
    chk("stop2_busy_end", 32'(busy2), 32'd0);
    chk("stop2_txd_end", 32'(txd2), 32'd1);

    // Reset in the middle of a data bit with a second byte still queued
    push(1'b0, 8'h3C);
    push(1'b0, 8'h99);
    repeat (40) tick();
    chk("midrst_busy_before", 32'(busy1), 32'd1);
    chk("midrst_count_before", 32'(count1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_txd", 32'(txd1), 32'd1);
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_count", 32'(count1), 32'd0);
    chk("midrst_ready", 32'(ready1), 32'd1);
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("midrst_line_idle", 32'(txd1), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
